// File: rtl/root_5_en_multi_cycle.sv
// Integer fifth root by bit-serial binary search with one iterated multiplier.
// Optional ROOT_5_REMAINDER_EN adds rem = arg - res^5.
module root_5_en_multi_cycle #(
   parameter int w = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clk_en,
   input  logic                   arg_vld,
   input  logic [w-1:0]           arg,
   output logic                   busy,
   output logic                   res_vld,
`ifdef ROOT_5_REMAINDER_EN
   output logic [w-1:0]           rem,
`endif
   output logic [(w+4)/5-1:0]     res
);

   localparam int rw = (w + 4) / 5;
   localparam int pw = 5 * rw;
   localparam int bw = (rw > 1) ? $clog2(rw) : 1;
   localparam logic [rw-1:0] top = rw'(1) << (rw - 1);

   typedef enum logic {IDLE, CALC} state_t;

   state_t        state;
   logic [w-1:0]  a;
   logic [bw-1:0] b;
   logic [rw-1:0] r;
   logic [rw-1:0] t;
   logic [pw-1:0] p;
   logic [1:0]    s;
`ifdef ROOT_5_REMAINDER_EN
   logic [pw-1:0] pr;
`endif

   logic [pw-1:0] q;
   logic          hit;
   logic [rw-1:0] bit_b;
   logic [rw-1:0] r_new;
   logic [rw-1:0] t_next;

   // bit_b >> 1 is the next trial bit, valid whenever b > 0
   always_comb begin
      q      = p * pw'(t);
      hit    = q <= pw'(a);
      bit_b  = rw'(1) << b;
      r_new  = hit ? (r | bit_b) : r;
      t_next = r_new | (bit_b >> 1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         busy    <= 1'b0;
         res_vld <= 1'b0;
         res     <= '0;
         a       <= '0;
         b       <= '0;
         r       <= '0;
         t       <= '0;
         p       <= '0;
         s       <= '0;
`ifdef ROOT_5_REMAINDER_EN
         pr      <= '0;
         rem     <= '0;
`endif
      end else if (clk_en) begin
         res_vld <= 1'b0;
         case (state)
            IDLE: begin
               if (arg_vld) begin
                  a     <= arg;
                  b     <= bw'(rw - 1);
                  r     <= '0;
                  t     <= top;
                  p     <= pw'(top);
                  s     <= '0;
                  busy  <= 1'b1;
                  state <= CALC;
`ifdef ROOT_5_REMAINDER_EN
                  pr    <= '0;
`endif
               end
            end
            CALC: begin
               if (s != 2'd3) begin
                  p <= q;
                  s <= s + 2'd1;
               end else begin
                  r <= r_new;
`ifdef ROOT_5_REMAINDER_EN
                  if (hit) pr <= q;
`endif
                  if (b != '0) begin
                     b <= b - bw'(1);
                     t <= t_next;
                     p <= pw'(t_next);
                     s <= '0;
                  end else begin
                     res     <= r_new;
                     res_vld <= 1'b1;
                     busy    <= 1'b0;
                     state   <= IDLE;
`ifdef ROOT_5_REMAINDER_EN
                     rem     <= a - w'(hit ? q : pr);
`endif
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_root_5_en_multi_cycle.sv
// Scoreboard bench for root_5_en_multi_cycle (w=8).
// Define ROOT_5_REMAINDER_EN to also check rem.
module tb_root_5_en_multi_cycle;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clk_en = 1'b1;
   logic       arg_vld = 1'b0;
   logic [7:0] arg = '0;
   logic       busy;
   logic       res_vld;
   logic [1:0] res;
`ifdef ROOT_5_REMAINDER_EN
   logic [7:0] rem;
`endif

   root_5_en_multi_cycle #(.w(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .clk_en  (clk_en),
      .arg_vld (arg_vld),
      .arg     (arg),
      .busy    (busy),
      .res_vld (res_vld),
`ifdef ROOT_5_REMAINDER_EN
      .rem     (rem),
`endif
      .res     (res)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [1:0] r;
      int         acc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   ecnt = 0;
   logic en_last = 1'b0;

   always @(posedge clk) begin
      en_last <= clk_en;
      if (clk_en && rst_n) ecnt <= ecnt + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [1:0] root5(input int x);
      if (x >= 243) return 2'd3;
      if (x >= 32) return 2'd2;
      if (x >= 1) return 2'd1;
      return 2'd0;
   endfunction

   // Monitor: one pop per enabled edge that raised res_vld
   always @(negedge clk) begin
      if (rst_n && res_vld && en_last) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_res_vld: got res %0d expected no result", res);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk($sformatf("res(arg=%0d)", e.a), int'(res), int'(e.r));
            chk($sformatf("latency(arg=%0d)", e.a), ecnt - e.acc, 8);
`ifdef ROOT_5_REMAINDER_EN
            chk($sformatf("rem(arg=%0d)", e.a), int'(rem),
                int'(e.a) - int'(e.r) ** 5);
`endif
         end
      end
   end

   task automatic push(input logic [7:0] x, input logic [1:0] r);
      exp_t e;
      e.a = x;
      e.r = r;
      e.acc = ecnt;
      q.push_back(e);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 200; i++) begin
         if (q.size() == 0) break;
         @(negedge clk);
      end
      chk("result_timeout_pending", q.size(), 0);
      q.delete();
   endtask

   task automatic run(input logic [7:0] x, input logic [1:0] r);
      @(negedge clk);
      arg = x;
      arg_vld = 1'b1;
      @(posedge clk);
      #1 push(x, r);
      @(negedge clk);
      arg_vld = 1'b0;
      wait_done();
   endtask

   initial begin
      int n;
      logic [7:0] pv [4];
      pv[0] = 8'd0;
      pv[1] = 8'd1;
      pv[2] = 8'd32;
      pv[3] = 8'd243;

      repeat (3) @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_res_vld", res_vld, 0);
      chk("reset_res", res, 0);
      rst_n = 1'b1;

      run(8'd0, 2'd0);
      run(8'd1, 2'd1);
      run(8'd31, 2'd1);
      run(8'd32, 2'd2);
      run(8'd242, 2'd2);
      run(8'd243, 2'd3);
      run(8'd255, 2'd3);
      for (int x = 0; x < 256; x++) run(8'(x), root5(x));

      // busy-ignore: extra arg_vld on the next 3 edges
      @(negedge clk);
      arg = 8'd243;
      arg_vld = 1'b1;
      @(posedge clk);
      #1 push(8'd243, 2'd3);
      arg = 8'd1;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 3) arg_vld = 1'b0;
         if (busy) n++;
         else break;
      end
      chk("busy_cycles", n, 8);
      wait_done();
      repeat (12) @(negedge clk);

      // clock enable toggling
      @(negedge clk);
      arg = 8'd100;
      arg_vld = 1'b1;
      @(posedge clk);
      #1 push(8'd100, 2'd2);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         arg_vld = 1'b0;
         clk_en = ~clk_en;
         if (res_vld) n++;
      end
      clk_en = 1'b1;
      chk("res_vld_clocks_gated", n, 2);
      wait_done();

      // reset mid-operation
      @(negedge clk);
      arg = 8'd243;
      arg_vld = 1'b1;
      @(posedge clk);
      #1 push(8'd243, 2'd3);
      @(negedge clk);
      arg_vld = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      q.delete();
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_res", res, 0);
      chk("rst_res_vld", res_vld, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      run(8'd32, 2'd2);

      // round trip with pow_5 outputs
      for (int i = 0; i < 4; i++) run(pv[i], 2'(i));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
